// File: rtl/prod_ctrl_pkg.sv
// Shared types for the producer arbitration FSM.
// State encoding and the state-to-LED mapping live here.
package prod_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COMM  = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    localparam int LED_W = 4;

    function automatic logic [LED_W-1:0] state_led_f(state_e s);
        unique case (s)
            S_IDLE:  state_led_f = 4'b0001;
            S_COMM:  state_led_f = 4'b0010;
            S_WAIT:  state_led_f = 4'b0100;
            S_DRAIN: state_led_f = 4'b1000;
            default: state_led_f = 4'b0001;
        endcase
    endfunction

endpackage

// File: rtl/prod_ctrl_fsm_rise_det.sv
// Rising-edge detector for raw buttons.
// A button already held when reset releases yields no rise until re-pressed.
module rise_det #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] rise
);

    logic [W-1:0] prev_q;
    logic         arm_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= '0;
            arm_q  <= 1'b0;
        end else begin
            prev_q <= din;
            arm_q  <= 1'b1;
        end
    end

    // First cycle after reset only samples the level, it never fires
    assign rise = din & ~prev_q & {W{arm_q}};

endmodule

// File: rtl/prod_ctrl_fsm.sv
// Arbitrates N_CH producers into the shared slow-clock buffer,
// with a stall watchdog on the buffer-full wait.
module prod_ctrl_fsm
    import prod_ctrl_pkg::*;
#(
    parameter int N_CH     = 2,
    parameter int SEL_W    = 3,
    parameter int WAIT_MAX = 1000000,
    parameter int CNT_W    = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   start,
    input  logic              stop,
    input  logic              buffer_full,
    input  logic              buffer_empty,
    input  logic              data_2_valid,
    output logic [N_CH-1:0]   en,
    output logic [SEL_W-1:0]  sel,
    output logic [LED_W-1:0]  state_led,
    output logic              timeout
);

    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((WAIT_MAX == 0) ? 0 : WAIT_MAX - 1);

    state_e           state_q;
    logic [SEL_W-1:0] sel_q;
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;
    logic [N_CH-1:0]  start_rise;
    logic             stop_rise;

    rise_det #(.W(N_CH)) u_start_det (
        .clk  (clk),
        .rst  (rst),
        .din  (start),
        .rise (start_rise)
    );

    rise_det #(.W(1)) u_stop_det (
        .clk  (clk),
        .rst  (rst),
        .din  (stop),
        .rise (stop_rise)
    );

    // Lowest set index wins
    function automatic logic [SEL_W-1:0] prio_enc(logic [N_CH-1:0] v);
        prio_enc = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (v[i]) prio_enc = SEL_W'(i);
        end
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            sel_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (|start_rise) begin
                        state_q   <= S_COMM;
                        sel_q     <= prio_enc(start_rise);
                        timeout_q <= 1'b0;
                    end
                end
                S_COMM: begin
                    if (stop_rise) begin
                        state_q <= S_DRAIN;
                    end else if (buffer_full) begin
                        state_q <= S_WAIT;
                        cnt_q   <= '0;
                    end
                end
                S_WAIT: begin
                    if (stop_rise) begin
                        state_q <= S_DRAIN;
                    end else if (!buffer_full) begin
                        state_q <= S_COMM;
                    end else if (WAIT_MAX != 0 && cnt_q == CNT_LAST) begin
                        state_q   <= S_DRAIN;
                        timeout_q <= 1'b1;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (buffer_empty && !data_2_valid) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        en = '0;
        if (state_q == S_COMM) begin
            for (int i = 0; i < N_CH; i++) begin
                en[i] = (sel_q == SEL_W'(i));
            end
        end
    end

    assign sel       = sel_q;
    assign state_led = state_led_f(state_q);
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_prod_ctrl_fsm.sv
// Scenario bench for prod_ctrl_fsm; per-cycle expectations are queued
// with the stimulus and compared against the sampled outputs.
module tb_prod_ctrl_fsm;

    localparam logic [3:0] L_IDLE  = 4'b0001;
    localparam logic [3:0] L_COMM  = 4'b0010;
    localparam logic [3:0] L_WAIT  = 4'b0100;
    localparam logic [3:0] L_DRAIN = 4'b1000;

    typedef struct packed {
        logic [3:0] led;
        logic [2:0] sel;
        logic [1:0] en;
        logic       to;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] start = '0;
    logic       stop = 1'b0;
    logic       bf = 1'b0;
    logic       be = 1'b0;
    logic       dv = 1'b0;
    logic [1:0] en;
    logic [2:0] sel;
    logic [3:0] led;
    logic       to;

    obs_t exp_q[$];
    obs_t got_q[$];
    int   n_run  = 0;
    int   n_fail = 0;

    prod_ctrl_fsm #(
        .N_CH(2), .SEL_W(3), .WAIT_MAX(16), .CNT_W(5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .buffer_full  (bf),
        .buffer_empty (be),
        .data_2_valid (dv),
        .en           (en),
        .sel          (sel),
        .state_led    (led),
        .timeout      (to)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(logic [3:0] l, logic [2:0] s,
                                logic [1:0] e, logic t);
        obs_t o;
        o.led = l; o.sel = s; o.en = e; o.to = t;
        return o;
    endfunction

    function automatic obs_t cur();
        return mk(led, sel, en, to);
    endfunction

    // Queue expectation for the coming edge, sample on the following negedge
    task automatic tick(input obs_t e);
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        got_q.push_back(cur());
    endtask

    task automatic test_reset();
        obs_t e, g;
        int k = 0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        exp_q.push_back(mk(L_IDLE, 3'd0, 2'b00, 1'b0));
        got_q.push_back(cur());
        rst = 1'b1;
        tick(mk(L_IDLE, 3'd0, 2'b00, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_run++; k++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL reset step %0d: got led=%b sel=%0d en=%b to=%b, exp led=%b sel=%0d en=%b to=%b",
                         k, g.led, g.sel, g.en, g.to, e.led, e.sel, e.en, e.to);
            end
        end
    endtask

    task automatic test_start_hold();
        obs_t e, g;
        int k = 0;
        start = 2'b10;
        repeat (3) tick(mk(L_COMM, 3'd1, 2'b10, 1'b0));
        start = 2'b00;
        repeat (2) tick(mk(L_COMM, 3'd1, 2'b10, 1'b0));
        stop = 1'b1;
        tick(mk(L_DRAIN, 3'd1, 2'b00, 1'b0));
        stop = 1'b0; be = 1'b1;
        tick(mk(L_IDLE, 3'd1, 2'b00, 1'b0));
        be = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_run++; k++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL start_hold step %0d: got led=%b sel=%0d en=%b to=%b, exp led=%b sel=%0d en=%b to=%b",
                         k, g.led, g.sel, g.en, g.to, e.led, e.sel, e.en, e.to);
            end
        end
    endtask

    task automatic test_wait();
        obs_t e, g;
        int k = 0;
        start = 2'b01;
        tick(mk(L_COMM, 3'd0, 2'b01, 1'b0));
        start = 2'b00; bf = 1'b1;
        repeat (10) tick(mk(L_WAIT, 3'd0, 2'b00, 1'b0));
        bf = 1'b0;
        tick(mk(L_COMM, 3'd0, 2'b01, 1'b0));
        stop = 1'b1;
        tick(mk(L_DRAIN, 3'd0, 2'b00, 1'b0));
        stop = 1'b0; be = 1'b1;
        tick(mk(L_IDLE, 3'd0, 2'b00, 1'b0));
        be = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_run++; k++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL wait step %0d: got led=%b sel=%0d en=%b to=%b, exp led=%b sel=%0d en=%b to=%b",
                         k, g.led, g.sel, g.en, g.to, e.led, e.sel, e.en, e.to);
            end
        end
    endtask

    task automatic test_simultaneous();
        obs_t e, g;
        int k = 0;
        start = 2'b11;
        tick(mk(L_COMM, 3'd0, 2'b01, 1'b0));
        start = 2'b00; stop = 1'b1; bf = 1'b1;
        tick(mk(L_DRAIN, 3'd0, 2'b00, 1'b0));
        stop = 1'b0; bf = 1'b0; be = 1'b1;
        tick(mk(L_IDLE, 3'd0, 2'b00, 1'b0));
        be = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_run++; k++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL simultaneous step %0d: got led=%b sel=%0d en=%b to=%b, exp led=%b sel=%0d en=%b to=%b",
                         k, g.led, g.sel, g.en, g.to, e.led, e.sel, e.en, e.to);
            end
        end
    endtask

    task automatic test_watchdog();
        obs_t e, g;
        int k = 0;
        start = 2'b10;
        tick(mk(L_COMM, 3'd1, 2'b10, 1'b0));
        start = 2'b00; bf = 1'b1;
        tick(mk(L_WAIT, 3'd1, 2'b00, 1'b0));
        repeat (15) tick(mk(L_WAIT, 3'd1, 2'b00, 1'b0));
        tick(mk(L_DRAIN, 3'd1, 2'b00, 1'b1));
        bf = 1'b0; be = 1'b1;
        tick(mk(L_IDLE, 3'd1, 2'b00, 1'b1));
        be = 1'b0; start = 2'b01;
        tick(mk(L_COMM, 3'd0, 2'b01, 1'b0));
        start = 2'b00; stop = 1'b1;
        tick(mk(L_DRAIN, 3'd0, 2'b00, 1'b0));
        stop = 1'b0; be = 1'b1;
        tick(mk(L_IDLE, 3'd0, 2'b00, 1'b0));
        be = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_run++; k++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL watchdog step %0d: got led=%b sel=%0d en=%b to=%b, exp led=%b sel=%0d en=%b to=%b",
                         k, g.led, g.sel, g.en, g.to, e.led, e.sel, e.en, e.to);
            end
        end
    endtask

    task automatic test_drain_valid();
        obs_t e, g;
        int k = 0;
        start = 2'b01;
        tick(mk(L_COMM, 3'd0, 2'b01, 1'b0));
        start = 2'b00; stop = 1'b1;
        tick(mk(L_DRAIN, 3'd0, 2'b00, 1'b0));
        stop = 1'b0; be = 1'b1; dv = 1'b1;
        repeat (2) tick(mk(L_DRAIN, 3'd0, 2'b00, 1'b0));
        start = 2'b10;
        tick(mk(L_DRAIN, 3'd0, 2'b00, 1'b0));
        start = 2'b00;
        tick(mk(L_DRAIN, 3'd0, 2'b00, 1'b0));
        dv = 1'b0;
        tick(mk(L_IDLE, 3'd0, 2'b00, 1'b0));
        be = 1'b0;
        tick(mk(L_IDLE, 3'd0, 2'b00, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_run++; k++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL drain_valid step %0d: got led=%b sel=%0d en=%b to=%b, exp led=%b sel=%0d en=%b to=%b",
                         k, g.led, g.sel, g.en, g.to, e.led, e.sel, e.en, e.to);
            end
        end
    endtask

    task automatic test_async_reset();
        obs_t e, g;
        int k = 0;
        start = 2'b10;
        tick(mk(L_COMM, 3'd1, 2'b10, 1'b0));
        #2 rst = 1'b0;
        #1;
        exp_q.push_back(mk(L_IDLE, 3'd0, 2'b00, 1'b0));
        got_q.push_back(cur());
        @(negedge clk);
        rst = 1'b1;
        tick(mk(L_IDLE, 3'd0, 2'b00, 1'b0));
        tick(mk(L_IDLE, 3'd0, 2'b00, 1'b0));
        start = 2'b00;
        tick(mk(L_IDLE, 3'd0, 2'b00, 1'b0));
        start = 2'b10;
        tick(mk(L_COMM, 3'd1, 2'b10, 1'b0));
        start = 2'b00; stop = 1'b1;
        tick(mk(L_DRAIN, 3'd1, 2'b00, 1'b0));
        stop = 1'b0; be = 1'b1;
        tick(mk(L_IDLE, 3'd1, 2'b00, 1'b0));
        be = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_run++; k++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL async_reset step %0d: got led=%b sel=%0d en=%b to=%b, exp led=%b sel=%0d en=%b to=%b",
                         k, g.led, g.sel, g.en, g.to, e.led, e.sel, e.en, e.to);
            end
        end
    endtask

    initial begin
        test_reset();
        test_start_hold();
        test_wait();
        test_simultaneous();
        test_watchdog();
        test_drain_valid();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/prod_ctrl_fsm.md
Name: prod_ctrl_fsm

Overview:
- Parametrised control FSM that arbitrates N_CH data producers (Fibonacci, Timer, future sources) into the shared slow-clock buffer.
- Generalises the current two-producer control: start buttons are a vector, and the active channel is held in an index register.
- Adds a stall watchdog on the buffer-full wait and a sticky timeout flag.
- Sits in the top level, between the raw buttons and the producer enables / state LEDs.

Parameters:
- N_CH, 2, number of producer channels; 1..8.
- SEL_W, 3, width of the channel index; must satisfy 2**SEL_W >= N_CH.
- WAIT_MAX, 1000000, maximum clk cycles allowed in S_WAIT before forced drain; 0 disables the watchdog.
- CNT_W, 20, watchdog counter width; must satisfy 2**CNT_W > WAIT_MAX.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset; asynchronous, active-low.
- start  in  N_CH  raw start/continue buttons, one per channel.
- stop  in  1  raw stop button.
- buffer_full  in  1  buffer full flag, level.
- buffer_empty  in  1  buffer empty flag, level.
- data_2_valid  in  1  consumer side still holds valid data.
- en  out  N_CH  producer enables, one-hot or zero.
- sel  out  SEL_W  index of the active channel.
- state_led  out  4  one-hot state indicator: bit0 IDLE, bit1 COMM, bit2 WAIT, bit3 DRAIN.
- timeout  out  1  sticky flag: the watchdog forced a drain.

Behaviour:
- Edge detect: each of start[i] and stop has a prev register (reset 0).
  - rise = din & ~prev, combinational.
  - A button held high produces exactly one rise.
- State transitions take effect on the clk edge where the rise is first seen, i.e. 1-cycle latency from the input being sampled high.
- Reset (rst=0, asynchronous):
  - state=S_IDLE, sel=0, wait counter=0, timeout=0, all prev registers=0.
  - Outputs: en=0, state_led=4'b0001.
- Reset asserted mid-operation aborts immediately; en drops asynchronously.
- S_IDLE:
  - Any start rise -> S_COMM; sel = lowest index with a rise (fixed priority, index 0 highest).
  - timeout is cleared on this transition.
  - A stop rise is ignored.
- S_COMM:
  - stop rise -> S_DRAIN (stop has priority over buffer_full in the same cycle).
  - else buffer_full=1 -> S_WAIT; wait counter is cleared.
  - Start rises are ignored; no channel switching while producing.
- S_WAIT:
  - stop rise -> S_DRAIN.
  - else buffer_full=0 -> S_COMM with the same sel.
  - else if WAIT_MAX!=0 and counter==WAIT_MAX-1 -> S_DRAIN, timeout<=1.
  - Otherwise the counter increments by 1; it saturates and never wraps.
- S_DRAIN:
  - buffer_empty=1 and data_2_valid=0 -> S_IDLE.
  - Start rises are ignored.
- en[i] = (state==S_COMM) && (sel==i), combinational from registered state; en=0 in every other state.
- sel holds its value outside S_IDLE→S_COMM transitions, so it remains readable for the display.
- If buffer_full=1 at the same edge as entry into S_COMM, the transition to S_WAIT occurs on the following cycle, so en is high for one cycle. The buffer must tolerate one extra enable.
- Illegal state encoding -> S_IDLE on the next edge.

Decomposition:
- Package prod_ctrl_pkg:
  - State localparams S_IDLE=2'd0, S_COMM=2'd1, S_WAIT=2'd2, S_DRAIN=2'd3.
  - State-to-LED one-hot mapping function.
- Sub-module rise_det: parametrised width, active-low asynchronous reset, prev register plus rise output. Instantiated once for start (width N_CH) and once for stop (width 1).
- Priority encoder: a function inside prod_ctrl_fsm, not a separate module.

Test Plan:
- Reset, then start=2'b10 for 3 cycles -> next edge: state_led=0010, sel=1, en=2'b10; en stays 2'b10 after start drops; no second transition.
- In COMM (sel=0): buffer_full=1 -> state_led=0100, en=0; buffer_full=0 after 10 cycles -> en=2'b01 on the next edge, timeout=0.
- Simultaneous start=2'b11 rise in IDLE -> sel=0, en=2'b01. Simultaneous stop rise and buffer_full=1 in COMM -> S_DRAIN.
- WAIT_MAX=16, buffer_full held 1 -> S_DRAIN exactly 16 cycles after entering WAIT, timeout=1. Drain completes (empty=1, valid=0) -> IDLE with timeout still 1; next start rise clears it.
- DRAIN with buffer_empty=1 but data_2_valid=1 -> stays in DRAIN; S_IDLE follows 1 cycle after valid falls. Start rises during DRAIN are ignored.
- rst=0 mid-COMM (asynchronous, between clock edges) -> en=0 and state_led=0001 immediately. After release, a button held high through reset yields no rise until it is released and pressed again.
